// File: rtl/systolic_result_deskew.sv
// Receive-side deskew for the systolic array: gathers diagonally skewed result lanes into an
// N x N matrix with a valid/ack handoff. Optional clamping selected by DESKEW_SATURATE_EN.
module systolic_result_deskew #(
  parameter int MATRIX_SIZE = 4,
  parameter int ACC_WIDTH   = 16,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  input  logic                                             in_valid,
  input  logic [MATRIX_SIZE-1:0][ACC_WIDTH-1:0]            TPU_outarray,
  input  logic                                             result_ack,
  output logic                                             busy,
  output logic                                             result_valid,
  output logic [MATRIX_SIZE*MATRIX_SIZE*OUT_WIDTH-1:0]     flattened_array_output,
  output logic                                             sat_flag
);

  localparam int N         = MATRIX_SIZE;
  localparam int LAST_STEP = 2 * N - 2;
  localparam int STEP_W    = (LAST_STEP > 0) ? $clog2(LAST_STEP + 1) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] CAPTURE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]                      state;
  logic [STEP_W-1:0]               step;
  // Element (i,j) lives at index N*N-1-(i*N+j), which puts (0,0) in the MSBs of the flat word.
  logic [N*N-1:0][OUT_WIDTH-1:0]   matrix;
  logic [N-1:0][OUT_WIDTH-1:0]     lane_out;

`ifdef DESKEW_SATURATE_EN
  logic [N-1:0] lane_sat;
  logic [N-1:0] lane_live;
  logic         sat_q;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    lane_out  = '0;
    lane_sat  = '0;
    lane_live = '0;
    for (int j = 0; j < N; j++) begin
      // In range iff all bits from the OUT_WIDTH sign bit upward agree.
      lane_sat[j]  = !((&TPU_outarray[j][ACC_WIDTH-1:OUT_WIDTH-1]) ||
                       !(|TPU_outarray[j][ACC_WIDTH-1:OUT_WIDTH-1]));
      lane_live[j] = (int'(step) >= j) && (int'(step) < j + N);
      if (lane_sat[j])
        lane_out[j] = TPU_outarray[j][ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
      else
        lane_out[j] = TPU_outarray[j][OUT_WIDTH-1:0];
    end
  end

  // Only lanes inside the diagonal window count; padding slots never raise the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sat_q <= 1'b0;
    else if (state == IDLE && start)
      sat_q <= 1'b0;
    else if (state == CAPTURE && in_valid && |(lane_sat & lane_live))
      sat_q <= 1'b1;
  end

  assign sat_flag = sat_q;
`else
  logic lane_unused;

  always_comb begin
    lane_out = '0;
    for (int j = 0; j < N; j++)
      lane_out[j] = TPU_outarray[j][OUT_WIDTH-1:0];
  end

  assign lane_unused = ^TPU_outarray;
  assign sat_flag    = 1'b0;
`endif

  // NOTE: the matrix is reset along with the control state so no stale result is ever visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is only ever updated with non-blocking assignments.
      state  <= IDLE;
      step   <= '0;
      matrix <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            step   <= '0;
            matrix <= '0;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            // At step t only the anti-diagonal i+j == t carries data.
            for (int i = 0; i < N; i++)
              for (int j = 0; j < N; j++)
                if (int'(step) == i + j)
                  matrix[N*N-1-i*N-j] <= lane_out[j];
            if (int'(step) == LAST_STEP)
              state <= DONE;
            else
              step <= step + STEP_W'(1);
          end
        end
        DONE: begin
          if (result_ack)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy                   = (state != IDLE);
  assign result_valid           = (state == DONE);
  assign flattened_array_output = matrix;

endmodule

// File: tb/tb_systolic_result_deskew.sv
// Randomized self-checking bench for systolic_result_deskew against a matrix-level reference
// model; honours DESKEW_SATURATE_EN the same way the design does.
module tb_systolic_result_deskew;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int OW    = 8;
  localparam int FW    = N * N * OW;
  localparam int STEPS = 2 * N - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic                  in_valid;
  logic [N-1:0][AW-1:0]  lanes;
  logic                  result_ack;
  logic                  busy;
  logic                  result_valid;
  logic [FW-1:0]         flat;
  logic                  sat_flag;

  systolic_result_deskew #(
    .MATRIX_SIZE (N),
    .ACC_WIDTH   (AW),
    .OUT_WIDTH   (OW)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .start                  (start),
    .in_valid               (in_valid),
    .TPU_outarray           (lanes),
    .result_ack             (result_ack),
    .busy                   (busy),
    .result_valid           (result_valid),
    .flattened_array_output (flat),
    .sat_flag               (sat_flag)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference: accumulator value of every result element, and the matrix it should produce.
  logic [AW-1:0] src [N][N];
  logic [FW-1:0] exp_mat;
  logic          exp_sat;

  task automatic check(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit clamps(input logic [AW-1:0] v);
    int s;
    s = int'($signed(v));
    return (s > (1 << (OW - 1)) - 1) || (s < -(1 << (OW - 1)));
  endfunction

  function automatic logic [OW-1:0] reduce(input logic [AW-1:0] v);
`ifdef DESKEW_SATURATE_EN
    if (clamps(v))
      return v[AW-1] ? OW'(1 << (OW - 1)) : OW'((1 << (OW - 1)) - 1);
`endif
    return v[OW-1:0];
  endfunction

  function automatic logic [OW-1:0] elem(input logic [FW-1:0] m, input int i, input int j);
    return m[(N*N - i*N - j)*OW - 1 -: OW];
  endfunction

  task automatic build_expected();
    exp_mat = '0;
    exp_sat = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        exp_mat[(N*N - i*N - j)*OW - 1 -: OW] = reduce(src[i][j]);
`ifdef DESKEW_SATURATE_EN
        if (clamps(src[i][j])) exp_sat = 1'b1;
`endif
      end
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        src[i][j] = AW'(16 * i + j);
  endtask

  task automatic fill_random(input bit in_range_only);
    logic [7:0] b;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        b = 8'($urandom);
        if (!in_range_only && $urandom_range(0, 3) == 0)
          src[i][j] = AW'($urandom);
        else
          src[i][j] = {{(AW-8){b[7]}}, b};
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_step(input int t, input bit fixed_pad);
    for (int j = 0; j < N; j++) begin
      if (t - j >= 0 && t - j < N)
        lanes[j] = src[t-j][j];
      else
        lanes[j] = fixed_pad ? 16'hFFFF : AW'($urandom);
    end
  endtask

  task automatic drive_junk();
    for (int j = 0; j < N; j++) lanes[j] = AW'($urandom);
  endtask

  // gap_mode: 0 back-to-back, 1 three idle cycles after step 2, 2 random idle cycles.
  task automatic run_capture(input int gap_mode, input bit fixed_pad);
    int gaps;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_on_start", FW'(busy), FW'(1));
    check("cleared_on_start", flat, '0);
    check("sat_clear_on_start", FW'(sat_flag), FW'(0));
    for (int t = 0; t < STEPS; t++) begin
      gaps = (gap_mode == 1) ? ((t == 3) ? 3 : 0) : (gap_mode == 2 ? $urandom_range(0, 2) : 0);
      repeat (gaps) begin
        in_valid = 1'b0;
        drive_junk();
        tick();
        check("valid_low_in_gap", FW'(result_valid), FW'(0));
        check("busy_in_gap", FW'(busy), FW'(1));
      end
      in_valid = 1'b1;
      drive_step(t, fixed_pad);
      tick();
      check("result_valid_timing", FW'(result_valid), FW'(t == STEPS - 1));
    end
    in_valid = 1'b0;
    build_expected();
    check("matrix", flat, exp_mat);
    check("sat_flag", FW'(sat_flag), FW'(exp_sat));
  endtask

  task automatic hold_done(input int cycles);
    repeat (cycles) begin
      start    = 1'($urandom);
      in_valid = 1'($urandom);
      drive_junk();
      tick();
      check("frozen_matrix", flat, exp_mat);
      check("valid_held", FW'(result_valid), FW'(1));
      check("busy_in_done", FW'(busy), FW'(1));
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic ack_done(input bit with_start);
    result_ack = 1'b1;
    start      = with_start;
    tick();
    result_ack = 1'b0;
    start      = 1'b0;
    check("valid_drop_on_ack", FW'(result_valid), FW'(0));
    check("idle_after_ack", FW'(busy), FW'(0));
    repeat (2) begin
      in_valid = 1'b1;
      drive_junk();
      tick();
      check("stay_idle", FW'(busy), FW'(0));
      check("matrix_held_idle", flat, exp_mat);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    in_valid   = 1'b0;
    result_ack = 1'b0;
    lanes      = '0;
    tick();
    tick();
    check("reset_busy", FW'(busy), FW'(0));
    check("reset_valid", FW'(result_valid), FW'(0));
    check("reset_matrix", flat, '0);
    check("reset_sat", FW'(sat_flag), FW'(0));
    rst = 1'b0;
    tick();

    // Counting pattern with 0xFFFF padding, back-to-back then with a stall gap.
    fill_pattern();
    run_capture(0, 1'b1);
    check("elem_1_2", FW'(elem(flat, 1, 2)), FW'(8'h12));
    check("elem_3_1", FW'(elem(flat, 3, 1)), FW'(8'h31));
    ack_done(1'b0);
    fill_pattern();
    run_capture(1, 1'b1);
    ack_done(1'b0);

    // Long hold in DONE with start/in_valid toggling.
    fill_random(1'b0);
    run_capture(0, 1'b0);
    hold_done(10);
    ack_done(1'b0);

    // Asynchronous reset in the middle of a capture.
    fill_random(1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 3; t++) begin
      in_valid = 1'b1;
      drive_step(t, 1'b0);
      tick();
    end
    drive_step(3, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", FW'(busy), FW'(0));
    check("async_rst_matrix", flat, '0);
    check("async_rst_sat", FW'(sat_flag), FW'(0));
    tick();
    tick();
    check("rst_hold_valid", FW'(result_valid), FW'(0));
    check("rst_hold_matrix", flat, '0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    fill_random(1'b0);
    run_capture(2, 1'b0);
    ack_done(1'b0);

    // Out-of-range corner elements.
    fill_random(1'b1);
    src[0][0] = 16'h0200;
    src[N-1][N-1] = 16'hFE00;
    run_capture(0, 1'b0);
`ifdef DESKEW_SATURATE_EN
    check("corner_00", FW'(elem(flat, 0, 0)), FW'(8'h7F));
    check("corner_33", FW'(elem(flat, N-1, N-1)), FW'(8'h80));
    check("corner_sat", FW'(sat_flag), FW'(1));
`else
    check("corner_00", FW'(elem(flat, 0, 0)), FW'(8'h00));
    check("corner_33", FW'(elem(flat, N-1, N-1)), FW'(8'h00));
    check("corner_sat", FW'(sat_flag), FW'(0));
`endif
    ack_done(1'b0);

    // start together with ack is dropped; a later start runs normally.
    fill_random(1'b0);
    run_capture(0, 1'b0);
    ack_done(1'b1);
    fill_random(1'b0);
    run_capture(2, 1'b0);
    ack_done(1'b0);

    // Randomized runs.
    for (int k = 0; k < 8; k++) begin
      fill_random(1'b0);
      run_capture(2, 1'b0);
      hold_done($urandom_range(0, 3));
      ack_done(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
